// File: rtl/tile_resolve.sv
// tile_resolve: walks a finished tile through the tile buffer's 2x2 quad read
// port, converts each pixel to RGBA8 and streams the tile in scanline order,
// four pixels per 128-bit beat. Even rows go straight to the output FIFO; odd
// rows are parked in a line buffer and replayed after the even row.
module tile_resolve #(
  parameter int POS_ADDRW   = 8,
  parameter int TILE_WIDTH  = 128,
  parameter int TILE_HEIGHT = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  i_tb_ready,
  output logic [POS_ADDRW-1:0]  o_rd_x,
  output logic [POS_ADDRW-1:0]  o_rd_y,
  output logic                  o_rd_valid,
  input  logic [3:0][71:0]      i_rd_data,
  input  logic                  i_rd_valid,
  output logic [127:0]          o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_tuser
);

  localparam int BEATS_ROW = TILE_WIDTH / 4;
  localparam int IDXW      = (BEATS_ROW > 1) ? $clog2(BEATS_ROW) : 1;
  localparam int PTRW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW      = PTRW + 1;

  localparam logic [IDXW-1:0]      IDX_LAST = IDXW'(BEATS_ROW - 1);
  localparam logic [POS_ADDRW-1:0] Y_LAST   = POS_ADDRW'(TILE_HEIGHT - 2);
  localparam logic [CNTW:0]        DEPTH_L  = (CNTW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EVEN, ODD, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [POS_ADDRW-1:0]  y_q, y_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  phase_b_q, phase_b_d;
  logic                  done_q, done_d;

  logic                  issue_a, issue_b, lb_rd;
  logic                  free_ok;
  logic [CNTW-1:0]       inflight_q;

  // Output FIFO, entries are {tuser, tlast, data}
  logic [129:0]          fifo_mem [FIFO_DEPTH];
  logic [PTRW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]       count_q;
  logic                  push, pop;
  logic [129:0]          push_word, head;

  // Quad read return path and odd-row line buffer
  logic                  a_pend_q, b_pend_q, lb_pend_q;
  logic [IDXW-1:0]       b_idx_q;
  logic                  b_first_q, lb_last_q;
  logic [63:0]           half_even_q, half_odd_q;
  logic [127:0]          lb_mem [BEATS_ROW];
  logic [127:0]          lb_q;
  logic [3:0][31:0]      px;
  logic                  unused_bits;

  // Convert the four returned pixels to RGBA8; depth and colour LSBs drop out
  always_comb begin
    unused_bits = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      px[i] = {8'hFF, i_rd_data[i][71:64], i_rd_data[i][55:48], i_rd_data[i][39:32]};
      unused_bits = unused_bits ^ (^{i_rd_data[i][63:56], i_rd_data[i][47:40], i_rd_data[i][31:0]});
    end
  end

  // A new beat may be started only if it is guaranteed a FIFO slot
  assign free_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_L;

  // Next-state and read issue; the second read of a pair is never gated
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    idx_d     = idx_q;
    phase_b_d = phase_b_q;
    done_d    = 1'b0;
    issue_a   = 1'b0;
    issue_b   = 1'b0;
    lb_rd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = EVEN;
          y_d       = '0;
          idx_d     = '0;
          phase_b_d = 1'b0;
        end
      end
      EVEN: begin
        if (phase_b_q) begin
          issue_b   = 1'b1;
          phase_b_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ODD;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end else if (i_tb_ready && free_ok) begin
          issue_a   = 1'b1;
          phase_b_d = 1'b1;
        end
      end
      ODD: begin
        if (free_ok) begin
          lb_rd = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (y_q == Y_LAST) begin
              state_d = DRAIN;
            end else begin
              y_d     = y_q + POS_ADDRW'(2);
              state_d = EVEN;
            end
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      DRAIN: begin
        // Leave as the final beat handshakes so o_done lands the cycle after
        if (inflight_q == '0 && (count_q == '0 || (count_q == CNTW'(1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, coordinates and done pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      y_q       <= '0;
      idx_q     <= '0;
      phase_b_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      phase_b_q <= phase_b_d;
      done_q    <= done_d;
    end
  end

  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_rd_valid = issue_a | issue_b;
  assign o_rd_x     = o_rd_valid ? POS_ADDRW'({idx_q, issue_b, 1'b0}) : '0;
  assign o_rd_y     = o_rd_valid ? y_q : '0;

  // Track outstanding reads and beats that have reserved a FIFO slot
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      lb_pend_q  <= 1'b0;
      inflight_q <= '0;
    end else begin
      a_pend_q   <= issue_a;
      b_pend_q   <= issue_b;
      lb_pend_q  <= lb_rd;
      inflight_q <= inflight_q + CNTW'(issue_a | lb_rd) - CNTW'(b_pend_q | lb_pend_q);
    end
  end

  // Assemble half beats, fill the line buffer, and read it back for odd rows
  always_ff @(posedge clk) begin
    if (issue_b) begin
      b_idx_q   <= idx_q;
      b_first_q <= (y_q == '0) && (idx_q == '0);
    end
    if (a_pend_q && i_rd_valid) begin
      half_even_q <= {px[1], px[0]};
      half_odd_q  <= {px[3], px[2]};
    end
    if (b_pend_q && i_rd_valid) begin
      lb_mem[b_idx_q] <= {px[3], px[2], half_odd_q};
    end
    if (lb_rd) begin
      lb_q      <= lb_mem[idx_q];
      lb_last_q <= (y_q == Y_LAST) && (idx_q == IDX_LAST);
    end
  end

  // FIFO write source: even-row beat from the quad port or odd-row beat from the line buffer
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (b_pend_q && i_rd_valid) begin
      push      = 1'b1;
      push_word = {b_first_q, 1'b0, px[1], px[0], half_even_q};
    end else if (lb_pend_q) begin
      push      = 1'b1;
      push_word = {1'b0, lb_last_q, lb_q};
    end
  end

  assign o_tvalid = (count_q != '0);
  assign pop      = o_tvalid & i_tready;

  // Present the FIFO head, zeroed when nothing is valid
  always_comb begin
    head = fifo_mem[rd_ptr_q];
    {o_tuser, o_tlast, o_tdata} = o_tvalid ? head : '0;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_word;
  end

endmodule

// File: doc/tile_resolve.md
Name: tile_resolve

Overview:
- Downstream consumer of the tile buffer. After rasterisation of a tile completes, it walks the whole tile through the buffer's 2x2-quad read port.
- Converts each 72-bit pixel ({color48, depth24}) to 32-bit RGBA8.
- Emits the tile in row-major scanline order as 128-bit stream beats, 4 pixels per beat, for the AXI writeback DMA.
- Reorders quad-shaped reads into scanlines using an internal odd-row line buffer. Honours stream backpressure.

Parameters:
- POS_ADDRW, 8, width of tile-local x/y read coordinates.
- TILE_WIDTH, 128, tile width in pixels; must be a multiple of 4.
- TILE_HEIGHT, 64, tile height in pixels; must be even.
- FIFO_DEPTH, 4, output FIFO depth in beats; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_start  in  1  pulse; begin resolving the tile
- o_busy  out  1  resolve in progress
- o_done  out  1  one-cycle pulse after the last beat handshakes
- i_tb_ready  in  1  tile buffer ready (not clearing)
- o_rd_x  out  POS_ADDRW  quad read x (always even)
- o_rd_y  out  POS_ADDRW  quad read y (always even)
- o_rd_valid  out  1  quad read request
- i_rd_data  in  72 x [4]  quad data: [0]=(x,y), [1]=(x+1,y), [2]=(x,y+1), [3]=(x+1,y+1)
- i_rd_valid  in  1  quad data valid; arrives exactly 1 cycle after the request
- o_tdata  out  128  4 pixels; pixel at lowest x in [31:0]
- o_tvalid  out  1  stream valid
- i_tready  in  1  stream ready
- o_tlast  out  1  last beat of the tile
- o_tuser  out  1  first beat of the tile

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. On reset: state IDLE, FIFO emptied, in-flight credits zeroed. Outputs o_busy=0, o_done=0, o_rd_valid=0, o_rd_x=0, o_rd_y=0, o_tvalid=0, o_tlast=0, o_tuser=0, o_tdata=0.
- Reset mid-operation aborts immediately. Read data returning the cycle after reset is discarded.
- Pixel conversion: R=p[71:56], G=p[55:40], B=p[39:24]. Word = {8'hFF, R[15:8], G[15:8], B[15:8]}. Depth is dropped.
- States:
  - IDLE: i_start -> EVEN with y=0, x=0, o_busy=1.
  - EVEN: for row pair (y, y+1), x steps 0,4,...,TILE_WIDTH-4.
    - Each step issues two reads on consecutive cycles: quad (x,y), then quad (x+2,y).
    - Returned data forms beat_even = pixels (x..x+3, y), pushed to the FIFO, and beat_odd = (x..x+3, y+1), written to line buffer entry x/4.
    - After the last step: -> ODD.
  - ODD: reads line buffer entries 0..TILE_WIDTH/4-1 (1-cycle latency), one per cycle, pushed to the FIFO.
    - After the last entry: y+=2 and -> EVEN, or -> DRAIN if y+2==TILE_HEIGHT.
  - DRAIN: wait for the FIFO to empty -> IDLE. o_done=1 for one cycle, o_busy=0 in the same cycle.
- Read gating:
  - A read pair (EVEN) or line-buffer read (ODD) starts only when FIFO free slots minus in-flight beats >= 1.
  - In EVEN, i_tb_ready must also be 1.
  - Once the first read of a pair is issued, the second read issues the next cycle unconditionally.
  - The FIFO never overflows.
- Throughput: EVEN 2 cycles/beat, ODD 1 beat/cycle when unthrottled.
- Stream:
  - Standard valid/ready. o_tdata, o_tlast and o_tuser are stable while o_tvalid=1 and i_tready=0.
  - o_tuser=1 only on beat (row 0, x=0).
  - o_tlast=1 only on beat (row TILE_HEIGHT-1, x=TILE_WIDTH-4).
  - Beats per tile = TILE_WIDTH*TILE_HEIGHT/4 (2048 at defaults).
- i_start while o_busy=1 is ignored.
- i_rd_valid without an outstanding request is ignored.
- i_tb_ready dropping mid-tile stalls only new EVEN read pairs; a started pair completes.

Test Plan:
- Fill the buffer with pixel(x,y).R=x<<8, G=y<<8, B=0x1200; start with i_tready=1 -> 2048 beats in scanline order. Beat 0 = {FF000012,FF010012,FF020012,FF030012} (pixel 0 in [31:0]). tuser on beat 0 only, tlast on beat 2047 only, o_done 1 cycle after.
- Random i_tready (50%) over a full tile -> identical beat sequence to the first scenario. No beat dropped or duplicated; tdata/tlast/tuser stable while stalled.
- i_tready=0 for 100 cycles after start -> exactly FIFO_DEPTH (4) beats buffered, o_rd_valid stays low, then resumes correctly.
- i_tb_ready=0 at start for 20 cycles -> no read issued until it rises; the output is then correct.
- Reset asserted at beat 500 -> all outputs at reset values next cycle. A following i_start produces the full correct tile from beat 0.
- i_start pulsed while busy -> ignored; exactly 2048 beats and one o_done.
